// File: rtl/seg7_scan_driver_if.sv
// Bus between the register file and the 7-segment scan driver.
// The master owns the display word and mode controls; the slave returns the pin-level drive.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 8
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     blank_mask;
   logic                  hex_mode;
   logic                  lz_en;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic [IDX_W-1:0]      digit_idx;

   modport master (
      output enable, load, value, dp_in, blank_mask, hex_mode, lz_en,
      input  seg, dp, an, digit_idx
   );

   modport slave (
      input  enable, load, value, dp_in, blank_mask, hex_mode, lz_en,
      output seg, dp, an, digit_idx
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadows a nibble word and
// scans one digit per refresh slot with guard blanking, BCD/hex decode and zero suppression.
module seg7_scan_driver #(
   parameter int DIGITS = 8,
   parameter int DIV    = 50000,
   parameter int GUARD  = 16
) (
   input logic               clk,
   input logic               rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_dpIn;
   logic [DIGITS-1:0]   r_blank;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_an;

   logic [3:0]          w_nibble;
   logic [6:0]          w_decoded;
   logic                w_lzBlank;
   logic [6:0]          w_segNext;
   logic                w_dpNext;
   logic [DIGITS-1:0]   w_anNext;

   function automatic logic [6:0] decodeNibble(input logic [3:0] n, input logic hex);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      if (!hex && (n > 4'd9)) s = 7'h7F;
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
         r_dpIn  <= '0;
         r_blank <= '0;
      end else if (bus.load) begin
         r_value <= bus.value;
         r_dpIn  <= bus.dp_in;
         r_blank <= bus.blank_mask;
      end
   end

   // Slot timing: disabling parks the scan at digit 0 so re-enabling always starts clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (!bus.enable) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A digit is a leading zero when it and every more-significant nibble are zero.
   assign w_nibble  = r_value[{r_idx, 2'b00} +: 4];
   assign w_decoded = decodeNibble(w_nibble, bus.hex_mode);
   assign w_lzBlank = bus.lz_en && (r_idx != '0) && ((r_value >> {r_idx, 2'b00}) == '0);

   always_comb begin
      w_anNext  = '1;
      w_segNext = 7'h7F;
      w_dpNext  = 1'b1;
      if (bus.enable) begin
         if (r_cnt >= GUARD_C) w_anNext = ~(DIGITS'(1) << r_idx);
         if (!r_blank[r_idx]) begin
            w_dpNext  = ~r_dpIn[r_idx];
            w_segNext = w_lzBlank ? 7'h7F : w_decoded;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= '1;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_anNext;
         r_seg <= w_segNext;
         r_dp  <= w_dpNext;
      end
   end

   assign bus.seg       = r_seg;
   assign bus.dp        = r_dp;
   assign bus.an        = r_an;
   assign bus.digit_idx = r_idx;

endmodule
